// File: rtl/dac_spi_tx_if.sv
// dac_spi_tx_if: sample input and SPI DAC pin bundle for dac_spi_tx.
// Ports: enable, sample_in (to tx); sclk, mosi, cs_n, busy, done, overrun (from tx).
interface dac_spi_tx_if;
    logic        enable;
    logic [15:0] sample_in;
    logic        sclk;
    logic        mosi;
    logic        cs_n;
    logic        busy;
    logic        done;
    logic        overrun;

    // Serializer side: consumes samples, drives the DAC pins and status.
    modport master (
        input  enable,
        input  sample_in,
        output sclk,
        output mosi,
        output cs_n,
        output busy,
        output done,
        output overrun
    );

    // Environment side: supplies samples, observes the DAC pins and status.
    modport slave (
        output enable,
        output sample_in,
        input  sclk,
        input  mosi,
        input  cs_n,
        input  busy,
        input  done,
        input  overrun
    );
endinterface

// File: rtl/dac_spi_tx.sv
// dac_spi_tx: fixed-rate 16-bit SPI (mode 0) DAC serializer with overrun flag.
// Ports: clk, rst (sync, active-high), bus (dac_spi_tx_if.master).
module dac_spi_tx #(
    parameter int CLK_DIV    = 4,
    parameter int SAMPLE_DIV = 2000
) (
    input  logic              clk,
    input  logic              rst,
    dac_spi_tx_if.master      bus
);

    localparam int TW = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;
    localparam int HW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    localparam logic [TW-1:0] TICK_LAST = TW'(SAMPLE_DIV - 1);
    localparam logic [HW-1:0] HC_LAST   = HW'(CLK_DIV - 1);

    typedef enum logic [1:0] {
        IDLE,
        SETUP,
        SHIFT,
        HOLD
    } state_e;

    state_e        state_q, state_d;
    logic [TW-1:0] tcnt_q, tcnt_d;
    logic [HW-1:0] hc_q, hc_d;
    logic [3:0]    bit_q, bit_d;
    logic          phase_q, phase_d;
    logic [14:0]   shreg_q, shreg_d;
    logic          sclk_q, sclk_d;
    logic          mosi_q, mosi_d;
    logic          cs_n_q, cs_n_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;
    logic          ovr_q, ovr_d;

    logic tick;
    logic hc_end;

    assign tick   = bus.enable && (tcnt_q == TICK_LAST);
    assign hc_end = (hc_q == HC_LAST);

    // Sample-rate ticker: free-runs only while enabled, parked at 0 otherwise.
    always_comb begin
        tcnt_d = '0;
        if (bus.enable && !tick) begin
            tcnt_d = tcnt_q + TW'(1);
        end
    end

    // Overrun is sticky while enabled; any tick outside IDLE is a drop.
    always_comb begin
        ovr_d = ovr_q;
        if (!bus.enable) begin
            ovr_d = 1'b0;
        end else if (tick && (state_q != IDLE)) begin
            ovr_d = 1'b1;
        end
    end

    // Frame sequencer. bit15 goes straight to mosi at capture, so the
    // shift register only needs to hold the remaining 15 bits.
    always_comb begin
        state_d = state_q;
        hc_d    = hc_q;
        bit_d   = bit_q;
        phase_d = phase_q;
        shreg_d = shreg_q;
        sclk_d  = sclk_q;
        mosi_d  = mosi_q;
        cs_n_d  = cs_n_q;
        busy_d  = busy_q;
        done_d  = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (tick) begin
                    shreg_d = bus.sample_in[14:0];
                    mosi_d  = bus.sample_in[15];
                    cs_n_d  = 1'b0;
                    busy_d  = 1'b1;
                    sclk_d  = 1'b0;
                    hc_d    = '0;
                    state_d = SETUP;
                end
            end

            SETUP: begin
                if (hc_end) begin
                    hc_d    = '0;
                    bit_d   = '0;
                    phase_d = 1'b0;
                    state_d = SHIFT;
                end else begin
                    hc_d = hc_q + HW'(1);
                end
            end

            SHIFT: begin
                if (hc_end) begin
                    hc_d = '0;
                    if (!phase_q) begin
                        phase_d = 1'b1;
                        sclk_d  = 1'b1;
                    end else begin
                        // Falling edge: advance data, or finish after bit 0.
                        phase_d = 1'b0;
                        sclk_d  = 1'b0;
                        if (bit_q == 4'd15) begin
                            mosi_d  = 1'b0;
                            state_d = HOLD;
                        end else begin
                            bit_d   = bit_q + 4'd1;
                            mosi_d  = shreg_q[14];
                            shreg_d = {shreg_q[13:0], 1'b0};
                        end
                    end
                end else begin
                    hc_d = hc_q + HW'(1);
                end
            end

            HOLD: begin
                if (hc_end) begin
                    hc_d    = '0;
                    cs_n_d  = 1'b1;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    state_d = IDLE;
                end else begin
                    hc_d = hc_q + HW'(1);
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            tcnt_q  <= '0;
            hc_q    <= '0;
            bit_q   <= '0;
            phase_q <= 1'b0;
            shreg_q <= '0;
            sclk_q  <= 1'b0;
            mosi_q  <= 1'b0;
            cs_n_q  <= 1'b1;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            ovr_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            tcnt_q  <= tcnt_d;
            hc_q    <= hc_d;
            bit_q   <= bit_d;
            phase_q <= phase_d;
            shreg_q <= shreg_d;
            sclk_q  <= sclk_d;
            mosi_q  <= mosi_d;
            cs_n_q  <= cs_n_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            ovr_q   <= ovr_d;
        end
    end

    assign bus.sclk    = sclk_q;
    assign bus.mosi    = mosi_q;
    assign bus.cs_n    = cs_n_q;
    assign bus.busy    = busy_q;
    assign bus.done    = done_q;
    assign bus.overrun = ovr_q;

endmodule

// File: tb/tb_dac_spi_tx.sv
// tb_dac_spi_tx: directed checks of dac_spi_tx framing, rate, overrun,
// reset, enable drop and data isolation on two instances.
module tb_dac_spi_tx;

    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    dac_spi_tx_if if0 ();
    dac_spi_tx_if if1 ();

    dac_spi_tx #(.CLK_DIV(2), .SAMPLE_DIV(100)) u_dut (
        .clk (clk),
        .rst (rst),
        .bus (if0.master)
    );

    dac_spi_tx #(.CLK_DIV(2), .SAMPLE_DIV(50)) u_ovr (
        .clk (clk),
        .rst (rst),
        .bus (if1.master)
    );

    int checks   = 0;
    int failures = 0;

    logic [1:0] sclk_w, cs_w, mosi_w, done_w;
    assign sclk_w = {if1.sclk, if0.sclk};
    assign cs_w   = {if1.cs_n, if0.cs_n};
    assign mosi_w = {if1.mosi, if0.mosi};
    assign done_w = {if1.done, if0.done};

    int          cyc = 0;
    logic [1:0]  p_sclk = 2'b00;
    logic [1:0]  p_cs   = 2'b11;
    int          fall_cnt [2] = '{0, 0};
    int          fall_cyc [2] = '{0, 0};
    int          end_cnt  [2] = '{0, 0};
    int          rises    [2] = '{0, 0};
    int          l_rises  [2] = '{0, 0};
    int          l_len    [2] = '{0, 0};
    int          done_cnt [2] = '{0, 0};
    logic [15:0] word     [2] = '{16'h0, 16'h0};
    logic [15:0] l_word   [2] = '{16'h0, 16'h0};
    logic        l_done   [2] = '{1'b0, 1'b0};

    // Pin-level SPI monitor: rebuilds each frame from mosi at sclk rises.
    always @(negedge clk) begin
        cyc    <= cyc + 1;
        p_sclk <= sclk_w;
        p_cs   <= cs_w;
        for (int i = 0; i < 2; i++) begin
            if (done_w[i]) done_cnt[i] <= done_cnt[i] + 1;
            if (p_cs[i] && !cs_w[i]) begin
                fall_cnt[i] <= fall_cnt[i] + 1;
                fall_cyc[i] <= cyc;
                word[i]     <= 16'h0;
                rises[i]    <= 0;
            end else if (!p_cs[i] && cs_w[i]) begin
                end_cnt[i] <= end_cnt[i] + 1;
                l_len[i]   <= cyc - fall_cyc[i];
                l_word[i]  <= word[i];
                l_rises[i] <= rises[i];
                l_done[i]  <= done_w[i];
            end else if (!cs_w[i] && !p_sclk[i] && sclk_w[i]) begin
                word[i]  <= {word[i][14:0], mosi_w[i]};
                rises[i] <= rises[i] + 1;
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick_wait();
        @(negedge clk);
        #1;
    endtask

    task automatic wait_fall(input int d, input int budget);
        int s;
        s = fall_cnt[d];
        for (int k = 0; k < budget && fall_cnt[d] == s; k++) tick_wait();
        check("wait_cs_fall", 32'(fall_cnt[d] != s), 32'd1);
    endtask

    task automatic wait_end(input int d, input int budget);
        int s;
        s = end_cnt[d];
        for (int k = 0; k < budget && end_cnt[d] == s; k++) tick_wait();
        check("wait_cs_rise", 32'(end_cnt[d] != s), 32'd1);
    endtask

    task automatic wait_rises(input int d, input int n, input int budget);
        for (int k = 0; k < budget && rises[d] < n; k++) tick_wait();
        check("wait_rises", 32'(rises[d]), 32'(n));
    endtask

    int prev_fall;
    int d0;
    int f0;

    initial begin
        if0.enable    = 1'b0;
        if1.enable    = 1'b0;
        if0.sample_in = 16'h0000;
        if1.sample_in = 16'h1234;

        // Reset state
        repeat (3) tick_wait();
        check("rst_cs_n",    32'(if0.cs_n),    32'd1);
        check("rst_sclk",    32'(if0.sclk),    32'd0);
        check("rst_mosi",    32'(if0.mosi),    32'd0);
        check("rst_busy",    32'(if0.busy),    32'd0);
        check("rst_done",    32'(if0.done),    32'd0);
        check("rst_overrun", 32'(if0.overrun), 32'd0);

        // Single frame
        if0.sample_in = 16'hA5C3;
        rst = 1'b0;
        if0.enable = 1'b1;
        wait_fall(0, 150);
        check("single_busy", 32'(if0.busy), 32'd1);
        wait_end(0, 100);
        check("single_word",  32'(l_word[0]),  32'hA5C3);
        check("single_rises", 32'(l_rises[0]), 32'd16);
        check("single_len",   32'(l_len[0]),   32'd68);
        check("single_done_at_rise", 32'(l_done[0]), 32'd1);
        tick_wait();
        check("single_done_cnt", 32'(done_cnt[0]), 32'd1);
        check("single_overrun",  32'(if0.overrun), 32'd0);
        if0.enable = 1'b0;
        repeat (3) tick_wait();

        // Rate check with ramping samples
        if0.sample_in = 16'h0000;
        if0.enable = 1'b1;
        prev_fall = 0;
        for (int i = 0; i < 5; i++) begin
            wait_fall(0, 150);
            if (i > 0) check("rate_spacing", 32'(fall_cyc[0] - prev_fall), 32'd100);
            prev_fall = fall_cyc[0];
            if0.sample_in = 16'((i + 1) * 16'h1111);
            wait_end(0, 100);
            check("rate_word", 32'(l_word[0]), 32'((i * 16'h1111) & 16'hFFFF));
        end
        if0.enable = 1'b0;
        check("rate_overrun", 32'(if0.overrun), 32'd0);

        // Overrun on the fast-tick instance
        if1.enable = 1'b1;
        wait_fall(1, 100);
        check("ovr_initial", 32'(if1.overrun), 32'd0);
        prev_fall = fall_cyc[1];
        wait_end(1, 100);
        check("ovr_word", 32'(l_word[1]), 32'h1234);
        check("ovr_set",  32'(if1.overrun), 32'd1);
        wait_fall(1, 100);
        check("ovr_spacing", 32'(fall_cyc[1] - prev_fall), 32'd100);
        check("ovr_sticky",  32'(if1.overrun), 32'd1);
        if1.enable = 1'b0;
        tick_wait();
        check("ovr_cleared", 32'(if1.overrun), 32'd0);
        wait_end(1, 100);

        // Reset mid-frame
        if0.sample_in = 16'hF0F0;
        if0.enable = 1'b1;
        wait_fall(0, 150);
        wait_rises(0, 8, 100);
        d0 = done_cnt[0];
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        tick_wait();
        check("mrst_cs_n", 32'(if0.cs_n), 32'd1);
        check("mrst_sclk", 32'(if0.sclk), 32'd0);
        check("mrst_mosi", 32'(if0.mosi), 32'd0);
        check("mrst_busy", 32'(if0.busy), 32'd0);
        check("mrst_done", 32'(if0.done), 32'd0);
        if0.sample_in = 16'h0FF0;
        wait_fall(0, 150);
        wait_end(0, 100);
        check("mrst_next_word",  32'(l_word[0]),  32'h0FF0);
        check("mrst_next_rises", 32'(l_rises[0]), 32'd16);
        check("mrst_done_cnt",   32'(done_cnt[0]), 32'(d0 + 1));

        // Enable drop mid-frame
        if0.sample_in = 16'h3C5A;
        wait_fall(0, 150);
        wait_rises(0, 4, 50);
        if0.enable = 1'b0;
        d0 = done_cnt[0];
        wait_end(0, 100);
        tick_wait();
        check("endrop_word",  32'(l_word[0]),   32'h3C5A);
        check("endrop_rises", 32'(l_rises[0]),  32'd16);
        check("endrop_done",  32'(done_cnt[0]), 32'(d0 + 1));
        f0 = fall_cnt[0];
        repeat (1000) tick_wait();
        check("endrop_quiet", 32'(fall_cnt[0]), 32'(f0));
        check("endrop_cs_n",  32'(if0.cs_n),    32'd1);

        // Data isolation
        if0.sample_in = 16'h9669;
        if0.enable = 1'b1;
        wait_fall(0, 150);
        f0 = end_cnt[0];
        for (int k = 0; k < 100 && end_cnt[0] == f0; k++) begin
            if0.sample_in = 16'($urandom);
            tick_wait();
        end
        check("iso_end",   32'(end_cnt[0] != f0), 32'd1);
        check("iso_word",  32'(l_word[0]),  32'h9669);
        check("iso_rises", 32'(l_rises[0]), 32'd16);
        if0.enable = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/dac_spi_tx.md
# dac_spi_tx

Serializes the 16-bit sample stream produced by the signal generator into a SPI DAC at a fixed, programmable sample rate. It sits directly downstream of `signal_generator`, taking `signal_out` as `sample_in`, and drives the board-level DAC pins. Every frame is 16 bits, MSB first, SPI mode 0 (CPOL=0, CPHA=0), framed by an active-low chip select. The block detects sample ticks that arrive while a frame is still in flight and flags them as overruns.

## Interface
- `CLK_DIV`, default 4: SCLK half-period in `clk` cycles; legal range ≥1.
- `SAMPLE_DIV`, default 2000: `clk` cycles between sample ticks (100 MHz / 2000 = 50 kS/s); legal range ≥2.
- Clock and reset: one clock; reset is synchronous and active-high.
- `clk` in 1: system clock.
- `rst` in 1: synchronous, active-high reset.
- `enable` in 1: run the sample-rate ticker; connected to the generator's `on`.
- `sample_in` in 16: unsigned sample; captured only on an accepted tick.
- `sclk` out 1: SPI clock; idles low.
- `mosi` out 1: SPI data, MSB first.
- `cs_n` out 1: DAC chip select, active low.
- `busy` out 1: high while a frame is in flight (`cs_n`=0).
- `done` out 1: one-cycle pulse when a frame completes.
- `overrun` out 1: sticky flag; a tick arrived while `busy`=1.

## Operation
- Reset values: `sclk`=0, `mosi`=0, `cs_n`=1, `busy`=0, `done`=0, `overrun`=0.
- Reset also forces the FSM to IDLE and clears the tick counter, half-period counter and bit counter.
- Reset takes effect mid-frame: the frame is aborted and `cs_n` returns high on the next edge.
- Ticker:
  - The counter runs 0..SAMPLE_DIV-1 while `enable`=1; `tick` is asserted when the count is SAMPLE_DIV-1, and the counter then wraps to 0.
  - While `enable`=0 the counter is held at 0, no ticks are issued, and `overrun` is cleared.
- FSM states: IDLE, SETUP, SHIFT, HOLD.
- IDLE:
  - On `tick`: capture `sample_in` into the shift register, set `cs_n`=0, `busy`=1, drive `mosi`=sample_in[15], and go to SETUP.
- SETUP:
  - Hold `sclk`=0 for CLK_DIV cycles, then go to SHIFT.
- SHIFT, 16 bits, each lasting 2×CLK_DIV cycles:
  - `sclk`=0 for CLK_DIV cycles, then `sclk`=1 for CLK_DIV cycles.
  - On each falling edge `mosi` advances to the next bit.
  - After the 16th falling edge `mosi`=0; go to HOLD.
- HOLD:
  - Hold `cs_n`=0 and `sclk`=0 for CLK_DIV cycles.
  - Then set `cs_n`=1, `busy`=0, pulse `done` for 1 cycle, and return to IDLE.
- A tick while state≠IDLE drops the sample (shift register untouched) and sets `overrun`=1.
- A tick in the same cycle that HOLD returns to IDLE counts as an overrun. A frame starts only from IDLE.
- `enable` falling mid-frame: the frame in flight completes normally; no further ticks are issued.
- `sample_in` changes during a frame do not affect the transmitted word.

## Timing
- All outputs are registered; there is no combinational path from inputs to outputs.
- Let edge E be the clock edge where `tick`=1 in IDLE:
  - `cs_n` falls, `busy` rises and `mosi`=bit15 all become visible after E.
  - The first `sclk` rise occurs CLK_DIV cycles after `cs_n` falls.
- Frame length: `cs_n` stays low for (1+32+1)×CLK_DIV = 34×CLK_DIV cycles.
- `done` is high in the cycle immediately after `cs_n` returns high.
- `mosi` is stable for CLK_DIV cycles on each side of every `sclk` rising edge, so the DAC samples on the rising edge.
- Loss-free operation requires SAMPLE_DIV ≥ 34×CLK_DIV + 1. Otherwise ticks are dropped and `overrun` sets.
- Throughput: one frame per SAMPLE_DIV cycles; consecutive `cs_n` falling edges are exactly SAMPLE_DIV cycles apart.

## Test plan
- **Single frame.** CLK_DIV=2, SAMPLE_DIV=100, `sample_in`=0xA5C3, `enable`=1 → exactly 16 `sclk` rises in one `cs_n`-low window of 68 cycles; `mosi` sampled on those rises reads 0xA5C3; one `done` pulse; `overrun`=0.
- **Rate check.** Same settings, 5 frames, ramping `sample_in` 0x0000,0x1111,…,0x4444 → `cs_n` falling edges every 100 cycles; the words captured match the value present at each tick.
- **Overrun.** CLK_DIV=2, SAMPLE_DIV=50 → ticks at 50 and 150 are dropped; `cs_n` falls every 100 cycles; `overrun`=1 after the first drop; `enable`=0 clears it.
- **Reset mid-frame.** Assert `rst` for 1 cycle at bit 7 of a frame → next cycle `cs_n`=1, `sclk`=0, `mosi`=0, `busy`=0, no `done`; the next frame after `rst` deasserts transmits a full 16 bits.
- **Enable drop.** Deassert `enable` at bit 3 → the current frame finishes with a correct word and `done`; no further `cs_n` activity for 1000 cycles.
- **Data isolation.** Toggle `sample_in` every cycle during a frame → the transmitted word equals the value captured at the tick.
